// File: rtl/rx_sched_pkg.sv
// Shared state encoding and default widths for the RX decimation strobe scheduler.
package rx_sched_pkg;
    localparam int RATE_W_DEF       = 8;
    localparam int COUNT_W_DEF      = 16;
    localparam int FLUSH_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE,
        WAIT_LOW
    } sched_state_e;
endpackage

// File: rtl/strobe_div_stage.sv
// One decimation stage: passes every (rate+1)-th input strobe while gated.
// load forces the count back to its idle value so the next strobe passes immediately.
module strobe_div_stage import rx_sched_pkg::*; #(
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [RATE_W-1:0] rate,
    input  logic              in_strobe,
    input  logic              gate,
    input  logic              load,
    output logic              out_strobe
);
    logic [RATE_W-1:0] cnt_q, cnt_d;

    assign out_strobe = (cnt_q == '0) && in_strobe && gate;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (in_strobe && gate)
            cnt_d = (cnt_q == '0) ? rate : cnt_q - RATE_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rx_strobe_sched.sv
// Run control and glitch-free rate sequencing for the two cascaded RX decimation stages.
module rx_strobe_sched import rx_sched_pkg::*; #(
    parameter int RATE_W       = RATE_W_DEF,
    parameter int COUNT_W      = COUNT_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run_req,
    input  logic               cfg_stb,
    input  logic [RATE_W-1:0]  rate1_cfg,
    input  logic [RATE_W-1:0]  rate2_cfg,
    input  logic [COUNT_W-1:0] burst_len,
    input  logic               strobe_in,
    output logic               enable_out,
    output logic               stage1_strobe,
    output logic               stage2_strobe,
    output logic               busy,
    output logic               done,
    output logic               cfg_pending
);
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

    sched_state_e       state_q, state_d;
    logic [RATE_W-1:0]  sh1_q, sh1_d, sh2_q, sh2_d;
    logic [RATE_W-1:0]  act1_q, act1_d, act2_q, act2_d;
    logic               pend_q, pend_d;
    logic [COUNT_W-1:0] burst_q, burst_d, scnt_q, scnt_d;
    logic [FLUSH_W-1:0] fcnt_q, fcnt_d;
    logic               gate, apply, s1, s2;
    logic [RATE_W-1:0]  rate1_eff, rate2_eff;

    assign gate  = (state_q == RUN) || (state_q == DRAIN);
    // New rates only take effect on an output-sample boundary, where both counters reload anyway.
    assign apply = gate && pend_q && s2;
    assign rate1_eff = apply ? sh1_q : act1_q;
    assign rate2_eff = apply ? sh2_q : act2_q;

    strobe_div_stage #(.RATE_W(RATE_W)) u_stage1 (
        .clock(clock), .reset_n(reset_n), .rate(rate1_eff),
        .in_strobe(strobe_in), .gate(gate), .load(!gate), .out_strobe(s1)
    );

    strobe_div_stage #(.RATE_W(RATE_W)) u_stage2 (
        .clock(clock), .reset_n(reset_n), .rate(rate2_eff),
        .in_strobe(s1), .gate(gate), .load(!gate), .out_strobe(s2)
    );

    always_comb begin
        state_d = state_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        act1_d  = act1_q;
        act2_d  = act2_q;
        pend_d  = pend_q;
        burst_d = burst_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                scnt_d = '0;
                if (pend_q || run_req) begin
                    act1_d = sh1_q;
                    act2_d = sh2_q;
                    pend_d = 1'b0;
                end
                if (run_req) begin
                    burst_d = burst_len;
                    fcnt_d  = FLUSH_INIT;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = RUN;
                else              fcnt_d  = fcnt_q - FLUSH_W'(1);
            end
            RUN: begin
                if (s2) scnt_d = scnt_q + COUNT_W'(1);
                if (s2 && burst_q != '0 && scnt_q == burst_q - COUNT_W'(1))
                    state_d = DONE;
                else if (!run_req)
                    state_d = DRAIN;
            end
            DRAIN:    if (s2) state_d = IDLE;
            DONE:     state_d = WAIT_LOW;
            WAIT_LOW: if (!run_req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (apply) begin
            act1_d = sh1_q;
            act2_d = sh2_q;
            pend_d = 1'b0;
        end
        // A strobe landing on the applying boundary stays pending for the next one.
        if (cfg_stb) begin
            sh1_d  = rate1_cfg;
            sh2_d  = rate2_cfg;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sh1_q   <= '0;
            sh2_q   <= '0;
            act1_q  <= '0;
            act2_q  <= '0;
            pend_q  <= 1'b0;
            burst_q <= '0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            act1_q  <= act1_d;
            act2_q  <= act2_d;
            pend_q  <= pend_d;
            burst_q <= burst_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign enable_out    = (state_q == FLUSH) || gate;
    assign busy          = enable_out;
    assign done          = (state_q == DONE);
    assign stage1_strobe = s1;
    assign stage2_strobe = s2;
    assign cfg_pending   = pend_q;
endmodule

// File: tb/tb_rx_strobe_sched.sv
// Directed and randomized runs checked against an arithmetic model of strobe spacing.
module tb_rx_strobe_sched;
    localparam int RATE_W = 8, COUNT_W = 16, FLUSH_CYCLES = 2;

    logic clock = 1'b0, reset_n = 1'b0, run_req = 1'b0, cfg_stb = 1'b0, strobe_in = 1'b0;
    logic [RATE_W-1:0]  rate1_cfg = '0, rate2_cfg = '0;
    logic [COUNT_W-1:0] burst_len = '0;
    logic enable_out, stage1_strobe, stage2_strobe, busy, done, cfg_pending;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    rx_strobe_sched #(.RATE_W(RATE_W), .COUNT_W(COUNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock(clock), .reset_n(reset_n), .run_req(run_req), .cfg_stb(cfg_stb),
        .rate1_cfg(rate1_cfg), .rate2_cfg(rate2_cfg), .burst_len(burst_len),
        .strobe_in(strobe_in), .enable_out(enable_out), .stage1_strobe(stage1_strobe),
        .stage2_strobe(stage2_strobe), .busy(busy), .done(done), .cfg_pending(cfg_pending)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic outs_chk(input string tag, input logic en, input logic s1, input logic s2,
                            input logic bz, input logic dn);
        chk({tag, "/enable"}, enable_out, en);
        chk({tag, "/s1"}, stage1_strobe, s1);
        chk({tag, "/s2"}, stage2_strobe, s2);
        chk({tag, "/busy"}, busy, bz);
        chk({tag, "/done"}, done, dn);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Model: with divide ratios R1/R2, the n-th input strobe (from 0) of an epoch yields a
    // stage-1 strobe when n%R1==0 and an output strobe when n%(R1*R2)==0. An applied config
    // starts a new epoch at that output strobe.
    task automatic do_run(input string nm, input bit prog, input int r1, input int r2,
                          input int bl, input int duty, input int drop_at,
                          input int cfg_a, input int c1, input int c2, input int cfg_b,
                          input int cfg_pct);
        int R1, R2, n, outs, sh1, sh2, nr1, nr2;
        bit pend, armed, fin_done, fin_drain, e1, e2;
        if (prog) begin
            rate1_cfg = RATE_W'(r1);
            rate2_cfg = RATE_W'(r2);
            cfg_stb = 1'b1;
            #1 chk({nm, "/pend_pre"}, cfg_pending, 1'b0);
            cyc();
            cfg_stb = 1'b0;
            #1 chk({nm, "/pend_set"}, cfg_pending, 1'b1);
            cyc();
            chk({nm, "/pend_idle_apply"}, cfg_pending, 1'b0);
        end
        run_req = 1'b1;
        burst_len = COUNT_W'(bl);
        strobe_in = 1'b1;
        #1 outs_chk({nm, "/idle"}, 0, 0, 0, 0, 0);
        cyc();
        for (int f = 0; f < FLUSH_CYCLES; f++) begin
            strobe_in = 1'($urandom_range(1));
            #1 outs_chk($sformatf("%s/flush%0d", nm, f), 1, 0, 0, 1, 0);
            cyc();
        end
        R1 = r1 + 1; R2 = r2 + 1; sh1 = r1; sh2 = r2;
        n = 0; outs = 0; pend = 0; armed = 0; fin_done = 0; fin_drain = 0;
        for (int t = 0; t < 3000; t++) begin
            strobe_in = (int'($urandom_range(99)) < duty);
            if (t == drop_at) run_req = 1'b0;
            nr1 = -1; nr2 = 0;
            if (t == cfg_a) begin
                nr1 = c1; nr2 = c2;
            end else if (t == cfg_b || int'($urandom_range(99)) < cfg_pct) begin
                nr1 = int'($urandom_range(3)); nr2 = int'($urandom_range(3));
            end
            if (nr1 >= 0) begin
                cfg_stb = 1'b1;
                rate1_cfg = RATE_W'(nr1);
                rate2_cfg = RATE_W'(nr2);
            end
            e1 = strobe_in && (n % R1 == 0);
            e2 = strobe_in && (n % (R1 * R2) == 0);
            #1;
            outs_chk($sformatf("%s/t%0d", nm, t), 1, e1, e2, 1, 0);
            chk($sformatf("%s/t%0d/pend", nm, t), cfg_pending, pend);
            if (strobe_in) n++;
            if (e2) begin
                outs++;
                if (pend) begin
                    R1 = sh1 + 1; R2 = sh2 + 1; n = 1; pend = 0;
                end
            end
            if (nr1 >= 0) begin
                sh1 = nr1; sh2 = nr2; pend = 1;
            end
            if (e2 && bl != 0 && outs == bl) fin_done = 1;
            else if (e2 && armed) fin_drain = 1;
            if (!run_req) armed = 1;
            cyc();
            cfg_stb = 1'b0;
            if (fin_done || fin_drain) break;
        end
        chk({nm, "/finished"}, fin_done || fin_drain, 1'b1);
        if (fin_done) begin
            #1 outs_chk({nm, "/done"}, 0, 0, 0, 0, 1);
            cyc();
            for (int w = 0; w < 3; w++) begin
                #1 outs_chk($sformatf("%s/wait%0d", nm, w), 0, 0, 0, 0, 0);
                cyc();
            end
            run_req = 1'b0;
            cyc(); cyc();
            chk({nm, "/pend_end"}, cfg_pending, 1'b0);
        end else if (fin_drain) begin
            #1 outs_chk({nm, "/drained"}, 0, 0, 0, 0, 0);
            chk({nm, "/pend_drained"}, cfg_pending, pend);
            cyc();
            chk({nm, "/pend_end"}, cfg_pending, 1'b0);
        end else begin
            run_req = 1'b0;
            reset_n = 1'b0;
            cyc();
            reset_n = 1'b1;
            cyc();
        end
    endtask

    initial begin
        repeat (2) cyc();
        outs_chk("reset", 0, 0, 0, 0, 0);
        chk("reset/pend", cfg_pending, 1'b0);
        reset_n = 1'b1;
        cyc();

        do_run("cont31",    1, 3, 1, 0, 100, 40, -1, 0, 0, -1, 0);
        do_run("burst5",    1, 0, 2, 5, 100, -1, -1, 0, 0, -1, 0);
        do_run("drop33",    1, 3, 3, 0, 100, 21, -1, 0, 0, -1, 0);
        do_run("cfg3to1",   1, 3, 1, 0, 100, 60, 10, 1, 1, -1, 0);
        do_run("duty33",    1, 1, 0, 0, 33,  50, -1, 0, 0, -1, 0);
        do_run("burst1",    1, 2, 1, 1, 100, -1, -1, 0, 0, -1, 0);
        do_run("donewins",  1, 0, 2, 3, 100, 6,  -1, 0, 0, -1, 0);
        do_run("cfgcoinc",  1, 1, 1, 0, 100, 30, 1,  2, 0, 4,  0);

        // Reset mid-run with a pending config: the next run must fall back to rates 0/0.
        rate1_cfg = 8'd3; rate2_cfg = 8'd3; cfg_stb = 1'b1;
        cyc();
        cfg_stb = 1'b0; run_req = 1'b1; strobe_in = 1'b1; burst_len = '0;
        repeat (6) cyc();
        rate1_cfg = 8'd2; rate2_cfg = 8'd2; cfg_stb = 1'b1;
        cyc();
        cfg_stb = 1'b0;
        #1 chk("rstrun/pend", cfg_pending, 1'b1);
        chk("rstrun/enable", enable_out, 1'b1);
        reset_n = 1'b0;
        #1 outs_chk("rst_async", 0, 0, 0, 0, 0);
        chk("rst_async/pend", cfg_pending, 1'b0);
        run_req = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        do_run("after_rst", 0, 0, 0, 4, 60, -1, -1, 0, 0, -1, 0);

        for (int k = 0; k < 6; k++)
            do_run($sformatf("rnd%0d", k), 1, int'($urandom_range(3)), int'($urandom_range(3)),
                   int'($urandom_range(4)), 30 + int'($urandom_range(70)),
                   10 + int'($urandom_range(70)), -1, 0, 0, -1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
